// File: rtl/minmax_tree.sv
// Pipelined N_IN-lane unsigned min/max reducer built as a registered binary comparator tree.
// Optional winner-index tracking is enabled by defining MINMAX_INDEX_EN.
module minmax_tree #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 5,
  localparam int LAT  = (N_IN == 1) ? 1 : $clog2(N_IN),
  localparam int IDXW = (N_IN == 1) ? 1 : $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  den_in,
  input  logic                  mode_in,
  input  logic [N_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  den_out
`ifdef MINMAX_INDEX_EN
  ,
  output logic [IDXW-1:0]       idx_out
`endif
);

  // Number of live nodes at the output of stage s (stage 0 = input lanes).
  function automatic int node_cnt(input int s);
    int n;
    n = N_IN;
    for (int i = 0; i < s; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // lvl[0] is the lane view of data_in; lvl[s] mirrors the stage-s registers.
  logic [WIDTH-1:0] lvl    [0:LAT][0:N_IN-1];
  logic [WIDTH-1:0] node_d [1:LAT][0:N_IN-1];
  logic [WIDTH-1:0] node_q [1:LAT][0:N_IN-1];
  logic             msel   [1:LAT];
  logic             mode_q [1:LAT];
  logic             vld_q  [1:LAT];
  logic             take_b;
`ifdef MINMAX_INDEX_EN
  logic [IDXW-1:0]  ilvl   [0:LAT][0:N_IN-1];
  logic [IDXW-1:0]  idx_d  [1:LAT][0:N_IN-1];
  logic [IDXW-1:0]  idx_q  [1:LAT][0:N_IN-1];
`endif

  always_comb begin
    take_b = 1'b0;
    for (int j = 0; j < N_IN; j++) begin
      lvl[0][j] = data_in[j*WIDTH +: WIDTH];
`ifdef MINMAX_INDEX_EN
      ilvl[0][j] = IDXW'(j);
`endif
    end
    for (int s = 1; s <= LAT; s++) begin
      for (int j = 0; j < N_IN; j++) begin
        lvl[s][j] = node_q[s][j];
`ifdef MINMAX_INDEX_EN
        ilvl[s][j] = idx_q[s][j];
`endif
      end
    end
    // Each stage compares using the mode of the sample it is currently reducing.
    msel[1] = mode_in;
    for (int s = 2; s <= LAT; s++) msel[s] = mode_q[s-1];

    for (int s = 1; s <= LAT; s++) begin
      for (int j = 0; j < N_IN; j++) begin
        node_d[s][j] = '0;
`ifdef MINMAX_INDEX_EN
        idx_d[s][j] = '0;
`endif
        if (j < node_cnt(s)) begin
          if (2*j + 1 < node_cnt(s-1)) begin
            // Strict compare: on equality the lower-index (left) node wins.
            take_b = msel[s] ? (lvl[s-1][2*j+1] > lvl[s-1][2*j])
                             : (lvl[s-1][2*j+1] < lvl[s-1][2*j]);
            node_d[s][j] = take_b ? lvl[s-1][2*j+1] : lvl[s-1][2*j];
`ifdef MINMAX_INDEX_EN
            idx_d[s][j] = take_b ? ilvl[s-1][2*j+1] : ilvl[s-1][2*j];
`endif
          end else begin
            node_d[s][j] = lvl[s-1][2*j];
`ifdef MINMAX_INDEX_EN
            idx_d[s][j] = ilvl[s-1][2*j];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= LAT; s++) begin
        vld_q[s]  <= 1'b0;
        mode_q[s] <= 1'b0;
        for (int j = 0; j < N_IN; j++) begin
          node_q[s][j] <= '0;
`ifdef MINMAX_INDEX_EN
          idx_q[s][j] <= '0;
`endif
        end
      end
    end else if (ce) begin
      vld_q[1] <= den_in;
      for (int s = 2; s <= LAT; s++) vld_q[s] <= vld_q[s-1];
      for (int s = 1; s <= LAT; s++) begin
        mode_q[s] <= msel[s];
        for (int j = 0; j < N_IN; j++) begin
          node_q[s][j] <= node_d[s][j];
`ifdef MINMAX_INDEX_EN
          idx_q[s][j] <= idx_d[s][j];
`endif
        end
      end
    end
  end

  assign data_out = node_q[LAT][0];
  assign den_out  = vld_q[LAT];
`ifdef MINMAX_INDEX_EN
  assign idx_out  = idx_q[LAT][0];
`endif

endmodule

// File: tb/tb_minmax_tree.sv
// Self-checking bench for minmax_tree (WIDTH=8, N_IN=5): scoreboard of reference results
// pushed on every accepted sample and popped whenever the pipeline delivers a valid result.
module tb_minmax_tree;

  localparam int WIDTH = 8;
  localparam int N_IN  = 5;
  localparam int LAT   = 3;
  localparam int IDXW  = 3;
  localparam int EW    = WIDTH + IDXW;

  logic                  clk;
  logic                  rst;
  logic                  ce;
  logic                  den_in;
  logic                  mode_in;
  logic [N_IN*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]      data_out;
  logic                  den_out;
  logic [IDXW-1:0]       obs_idx;
`ifdef MINMAX_INDEX_EN
  logic [IDXW-1:0]       idx_out;
  assign obs_idx = idx_out;
`else
  assign obs_idx = '0;
`endif

  minmax_tree #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .den_in(den_in),
    .mode_in(mode_in),
    .data_in(data_in),
    .data_out(data_out),
    .den_out(den_out)
`ifdef MINMAX_INDEX_EN
    ,
    .idx_out(idx_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;
  logic          mon_adv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: linear scan, replace only on strictly better value -> lowest index wins ties.
  function automatic logic [EW-1:0] ref_model(input logic [N_IN*WIDTH-1:0] d, input logic m);
    logic [WIDTH-1:0] best;
    logic [WIDTH-1:0] v;
    int bi;
    best = d[0 +: WIDTH];
    bi = 0;
    for (int k = 1; k < N_IN; k++) begin
      v = d[k*WIDTH +: WIDTH];
      if (m ? (v > best) : (v < best)) begin
        best = v;
        bi = k;
      end
    end
`ifdef MINMAX_INDEX_EN
    return {IDXW'(bi), best};
`else
    return {IDXW'(0), best};
`endif
  endfunction

  function automatic logic [N_IN*WIDTH-1:0] lanes(input logic [7:0] a, input logic [7:0] b,
                                                   input logic [7:0] c, input logic [7:0] d,
                                                   input logic [7:0] e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [N_IN*WIDTH-1:0] rand_lanes();
    logic [N_IN*WIDTH-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
    return r;
  endfunction

  // scoreboard: push on accepted samples, pop on each delivered result
  always @(posedge clk) begin
    mon_adv = 1'b0;
    if (rst) exp_q.delete();
    else if (ce) begin
      mon_adv = 1'b1;
      if (den_in) exp_q.push_back(ref_model(data_in, mode_in));
    end
    #1;
    if (mon_adv && den_out) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        last_exp = exp_q.pop_front();
        n_results++;
        check("result", {obs_idx, data_out}, last_exp);
      end
    end
  end

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic send(input logic [N_IN*WIDTH-1:0] d, input logic m);
    data_in = d;
    mode_in = m;
    den_in  = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    den_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int base;
  int cnt;

  initial begin
    rst = 1'b1; ce = 1'b1; den_in = 1'b0; mode_in = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data_out, 0);
    check("reset_den", den_out, 0);
    check("reset_idx", obs_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed tie / extreme case
    send(lanes(9, 3, 7, 3, 12), 1'b0);
    send(lanes(9, 3, 7, 3, 12), 1'b1);
    den_in = 1'b0;
    @(posedge clk); #1;
    check("t1_min_data", data_out, 3);
    check("t1_min_den", den_out, 1);
`ifdef MINMAX_INDEX_EN
    check("t1_min_idx", obs_idx, 1);
`endif
    @(posedge clk); #1;
    check("t1_max_data", data_out, 12);
`ifdef MINMAX_INDEX_EN
    check("t1_max_idx", obs_idx, 4);
`endif
    @(negedge clk);
    idle(4);

    // boundary patterns
    send(lanes(0, 255, 255, 0, 128), 1'b0);
    send(lanes(0, 255, 255, 0, 128), 1'b1);
    send(lanes(8'h5a, 8'h5a, 8'h5a, 8'h5a, 8'h5a), 1'b0);
    send(lanes(8'h5a, 8'h5a, 8'h5a, 8'h5a, 8'h5a), 1'b1);
    send(lanes(255, 254, 1, 0, 0), 1'b0);
    send(lanes(1, 1, 2, 200, 200), 1'b1);
    idle(6);

    // back-to-back random stream, alternating mode
    base = n_results;
    for (int i = 0; i < 16; i++) send(rand_lanes(), i[0]);
    idle(6);
    check("t2_count", n_results - base, 16);

    // ce stall mid-stream
    base = n_results;
    for (int i = 0; i < 4; i++) send(rand_lanes(), 1'($urandom_range(0, 1)));
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = rand_lanes();
      mode_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("t3_hold_data", data_out, 32'(last_exp[WIDTH-1:0]));
      check("t3_hold_den", den_out, 1);
      @(negedge clk);
    end
    ce = 1'b1;
    for (int i = 0; i < 4; i++) send(rand_lanes(), 1'($urandom_range(0, 1)));
    idle(6);
    check("t3_count", n_results - base, 8);

    // reset with samples in flight
    for (int i = 0; i < 4; i++) send(rand_lanes(), 1'b1);
    rst = 1'b1;
    #1;
    check("t4_rst_den", den_out, 0);
    check("t4_rst_data", data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    data_in = lanes(40, 30, 20, 10, 50);
    mode_in = 1'b0;
    den_in  = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      #1;
      den_in = 1'b0;
    end while (!den_out && cnt < 10);
    check("t4_latency", cnt, LAT);
    check("t4_data", data_out, 10);
    @(negedge clk);
    idle(6);

    check("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
